ldpc_ber_tester_din_framer: RTL

Sits between the Gaussian LLR generator (grng_16) and the LDPC decoder DIN slave. It turns the unframed 128-bit LLR stream into codeword-sized packets by counting beats and driving tlast on the last beat of each block. It can stop after a programmed number of blocks and reports how many blocks it has sent. Configuration comes from the regmap in the data clock domain; the regmap handles the CDC.

---
 rtl/ldpc_ber_tester_pkg.sv | 26 ++
 rtl/ldpc_ber_tester_axis_reg.sv | 57 +++++
 rtl/ldpc_ber_tester_din_framer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_ber_tester_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_ber_tester_pkg
// Shared definitions for the LDPC BER tester datapath blocks.
//   framer_state_e : framer FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   DEFAULT_DATA_W : default AXI-Stream data width
//   sat_inc        : increment that sticks at a caller-supplied maximum
// ---------------------------------------------------------------------------
package ldpc_ber_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } framer_state_e;

    localparam int DEFAULT_DATA_W = 128;

    // Counters narrower than 64 bits pass their all-ones value as max_val
    // and truncate the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_val);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/ldpc_ber_tester_axis_reg.sv
// ---------------------------------------------------------------------------
// ldpc_ber_tester_axis_reg
// Single-stage AXI-Stream pipeline register carrying data and tlast.
// Also used in front of the BER counter input.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_en                : upstream beats may be accepted when high
//   i_s_tdata/tlast/tvalid, o_s_tready : slave side
//   o_m_tdata/tlast/tvalid, i_m_tready : master side
// ---------------------------------------------------------------------------
module ldpc_ber_tester_axis_reg
    import ldpc_ber_tester_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_s_tdata,
    input  logic              i_s_tlast,
    input  logic              i_s_tvalid,
    output logic              o_s_tready,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic              o_m_tlast,
    output logic              o_m_tvalid,
    input  logic              i_m_tready
);

    logic              r_valid;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic              w_load;

    // The register can take a new beat when it is empty or being drained
    // in the same cycle, which gives full throughput without a skid buffer.
    assign o_s_tready = i_en && (!r_valid || i_m_tready);
    assign w_load     = i_s_tvalid && o_s_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= i_s_tlast;
            r_data  <= i_s_tdata;
        end else if (i_m_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_tdata  = r_data;
    assign o_m_tlast  = r_last;
    assign o_m_tvalid = r_valid;

endmodule

// File: rtl/ldpc_ber_tester_din_framer.sv
// ---------------------------------------------------------------------------
// ldpc_ber_tester_din_framer
// Frames the unframed LLR stream from the Gaussian generator into
// codeword-sized packets for the LDPC decoder DIN port: counts beats,
// tags the last beat of each block with tlast, optionally stops after a
// programmed number of blocks and reports blocks delivered.
//
// Ports:
//   data_clk, data_resetn       : clock, asynchronous active-low reset
//   start, stop                 : single-cycle control pulses
//   beats_per_block, block_limit: configuration, latched on start
//   s_axis_*                    : LLR input stream (no tlast)
//   m_axis_*                    : framed output stream to decoder DIN
//   busy, done                  : status (RUN/DRAIN, DONE)
//   blocks_sent                 : saturating count of tlast beats delivered
//
// Optional build macro LDPC_BER_TESTER_FRAMER_STATS_EN adds:
//   stall_cycles    : cycles with m_axis_tvalid=1 and m_axis_tready=0
//   underrun_cycles : cycles in RUN with s_axis_tvalid=0
// ---------------------------------------------------------------------------
module ldpc_ber_tester_din_framer
    import ldpc_ber_tester_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int BEAT_CNT_W = 16,
    parameter int BLK_CNT_W  = 64
) (
    input  logic                  data_clk,
    input  logic                  data_resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [BEAT_CNT_W-1:0] beats_per_block,
    input  logic [BLK_CNT_W-1:0]  block_limit,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [BLK_CNT_W-1:0]  blocks_sent
`ifdef LDPC_BER_TESTER_FRAMER_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           underrun_cycles
`endif
);

    localparam logic [BLK_CNT_W-1:0] BLK_ONES = '1;

    framer_state_e         r_state;
    framer_state_e         w_state_next;
    logic [BEAT_CNT_W-1:0] r_bpb;
    logic [BLK_CNT_W-1:0]  r_limit;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BLK_CNT_W-1:0]  r_in_blocks;
    logic [BLK_CNT_W-1:0]  r_blocks_sent;
    logic                  r_pending_stop;
    logic                  r_limit_hit;

    logic                  w_can_accept;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_is_last;
    logic                  w_clear;
    logic                  w_pending_set;
    logic                  w_limit_hit_set;
    logic [BLK_CNT_W-1:0]  w_in_blocks_inc;
    logic [BEAT_CNT_W-1:0] w_bpb_latch;

    // DRAIN only accepts beats that complete a partially received block.
    assign w_can_accept    = (r_state == ST_RUN) ||
                             ((r_state == ST_DRAIN) && (r_beat_cnt != '0));
    assign w_in_hs         = s_axis_tvalid && s_axis_tready;
    assign w_out_hs        = m_axis_tvalid && m_axis_tready;
    assign w_is_last       = (r_beat_cnt == (r_bpb - BEAT_CNT_W'(1)));
    assign w_in_blocks_inc = r_in_blocks + BLK_CNT_W'(1);
    assign w_bpb_latch     = (beats_per_block == '0) ? BEAT_CNT_W'(1) : beats_per_block;

    ldpc_ber_tester_axis_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk        (data_clk),
        .rst_n      (data_resetn),
        .i_en       (w_can_accept),
        .i_s_tdata  (s_axis_tdata),
        .i_s_tlast  (w_is_last),
        .i_s_tvalid (s_axis_tvalid),
        .o_s_tready (s_axis_tready),
        .o_m_tdata  (m_axis_tdata),
        .o_m_tlast  (m_axis_tlast),
        .o_m_tvalid (m_axis_tvalid),
        .i_m_tready (m_axis_tready)
    );

    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A stop that lands on the tlast handshake itself counts as finishing
    // the current block, so the framer drains right away.
    always_comb begin
        w_state_next    = r_state;
        w_clear         = 1'b0;
        w_pending_set   = 1'b0;
        w_limit_hit_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_in_hs && w_is_last && (r_limit != '0) &&
                    (w_in_blocks_inc == r_limit)) begin
                    w_limit_hit_set = 1'b1;
                    w_state_next    = ST_DRAIN;
                end else if (w_in_hs && w_is_last && (r_pending_stop || stop)) begin
                    w_state_next = ST_DRAIN;
                end else if (stop && (r_beat_cnt == '0) && !w_in_hs) begin
                    w_state_next = ST_DRAIN;
                end else if (stop) begin
                    w_pending_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if ((r_beat_cnt == '0) && !m_axis_tvalid) begin
                    w_state_next = r_limit_hit ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_RUN;
                end else if (stop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            r_bpb          <= '0;
            r_limit        <= '0;
            r_beat_cnt     <= '0;
            r_in_blocks    <= '0;
            r_blocks_sent  <= '0;
            r_pending_stop <= 1'b0;
            r_limit_hit    <= 1'b0;
        end else if (w_clear) begin
            r_bpb          <= w_bpb_latch;
            r_limit        <= block_limit;
            r_beat_cnt     <= '0;
            r_in_blocks    <= '0;
            r_blocks_sent  <= '0;
            r_pending_stop <= 1'b0;
            r_limit_hit    <= 1'b0;
        end else begin
            if (w_in_hs) begin
                if (w_is_last) begin
                    r_beat_cnt  <= '0;
                    r_in_blocks <= w_in_blocks_inc;
                end else begin
                    r_beat_cnt  <= r_beat_cnt + BEAT_CNT_W'(1);
                end
            end
            if (w_pending_set) begin
                r_pending_stop <= 1'b1;
            end
            if (w_limit_hit_set) begin
                r_limit_hit <= 1'b1;
            end
            if (w_out_hs && m_axis_tlast) begin
                r_blocks_sent <= BLK_CNT_W'(sat_inc(64'(r_blocks_sent), 64'(BLK_ONES)));
            end
        end
    end

    assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done        = (r_state == ST_DONE);
    assign blocks_sent = r_blocks_sent;

`ifdef LDPC_BER_TESTER_FRAMER_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_underrun_cycles;

    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            r_stall_cycles    <= '0;
            r_underrun_cycles <= '0;
        end else if (w_clear) begin
            r_stall_cycles    <= '0;
            r_underrun_cycles <= '0;
        end else begin
            if (m_axis_tvalid && !m_axis_tready) begin
                r_stall_cycles <= 32'(sat_inc(64'(r_stall_cycles), 64'(32'hFFFF_FFFF)));
            end
            if ((r_state == ST_RUN) && !s_axis_tvalid) begin
                r_underrun_cycles <= 32'(sat_inc(64'(r_underrun_cycles), 64'(32'hFFFF_FFFF)));
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign underrun_cycles = r_underrun_cycles;
`endif

endmodule
